// File: rtl/scan_chain_driver.sv
// scan_chain_driver
//   Serialises WORD_W-bit load words into a scan chain (LSB first) and
//   deserialises the bits returned from the end of the chain into readback
//   words (first-sampled bit in the LSB). One word takes WORD_W+1 cycles:
//   one accept cycle in IDLE followed by WORD_W shift cycles. A running
//   bit count pulses `done` once every CHAIN_LEN shifted bits.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-high
//   in_valid   : load word valid
//   in_ready   : driver accepts a load word this cycle (IDLE only)
//   in_data    : load word, shifted out LSB first
//   scan_en    : chain shift enable, high in every shifting cycle
//   scan_out   : serial data to DI of the first chain flop (0 when idle)
//   scan_in    : serial data from Q of the last chain flop
//   out_valid  : readback word valid
//   out_ready  : consumer accepts the readback word
//   out_data   : readback word
//   done       : one-cycle pulse after every CHAIN_LEN shifted bits
module scan_chain_driver #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              scan_en,
  output logic              scan_out,
  input  logic              scan_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              done
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  logic [0:0]        state_r;
  logic [IDX_W-1:0]  index_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [WORD_W-1:0] tx_r;
  logic [WORD_W-1:0] rx_r;
  logic              out_valid_r;
  logic [WORD_W-1:0] out_data_r;
  logic              done_r;

  logic              in_ready_s;
  logic              stall_s;
  logic              scan_en_s;
  logic              scan_out_s;
  logic              word_done_s;
  logic [WORD_W-1:0] rx_next_s;

  // Handshake, shift enable and serial data; everything is forced quiet
  // while reset is held so an aborted word produces no further pulses.
  always_comb begin
    in_ready_s  = 1'b0;
    stall_s     = 1'b0;
    scan_en_s   = 1'b0;
    scan_out_s  = 1'b0;
    word_done_s = 1'b0;
    rx_next_s   = rx_r;

    if (!reset && (state_r == ST_IDLE)) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end

    // The last bit of a word would overwrite an unconsumed readback word,
    // so the shift pauses in front of it until the consumer is ready.
    stall_s = (index_r == LAST_IDX) && out_valid_r && !out_ready;

    if (!reset && (state_r == ST_SHIFT) && !stall_s) begin
      scan_en_s  = 1'b1;
      scan_out_s = tx_r[index_r];
    end else begin
      scan_en_s  = 1'b0;
      scan_out_s = 1'b0;
    end

    // RX word including the bit sampled on this edge, so a completing word
    // can be presented without an extra cycle.
    rx_next_s[index_r] = scan_in;
    word_done_s        = scan_en_s && (index_r == LAST_IDX);
  end

  // Word FSM, shift registers, readback register and chain bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      index_r     <= {IDX_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      tx_r        <= {WORD_W{1'b0}};
      rx_r        <= {WORD_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WORD_W{1'b0}};
      done_r      <= 1'b0;
    end else begin
      // in_ready only in IDLE and scan_en only in SHIFT: mutually exclusive.
      if (in_valid && in_ready_s) begin
        tx_r    <= in_data;
        index_r <= {IDX_W{1'b0}};
        state_r <= ST_SHIFT;
      end else if (scan_en_s) begin
        rx_r <= rx_next_s;
        if (word_done_s) begin
          index_r <= {IDX_W{1'b0}};
          state_r <= ST_IDLE;
        end else begin
          index_r <= index_r + IDX_W'(1);
        end
      end

      // A completing word wins over a consume on the same edge, so
      // out_valid stays high and the new word replaces the old one.
      if (word_done_s) begin
        out_data_r  <= rx_next_s;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end

      if (scan_en_s) begin
        if (cnt_r == LAST_CNT) begin
          cnt_r  <= {CNT_W{1'b0}};
          done_r <= 1'b1;
        end else begin
          cnt_r  <= cnt_r + CNT_W'(1);
          done_r <= 1'b0;
        end
      end else begin
        done_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign scan_en   = scan_en_s;
  assign scan_out  = scan_out_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign done      = done_r;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Testbench for scan_chain_driver (WORD_W=8, CHAIN_LEN=64).
module tb_scan_chain_driver;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 64;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              scan_en;
  logic              scan_out;
  logic              scan_in;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              done;

  logic                 scan_in_drv;
  logic                 loop_mode;
  logic                 chain_clr;
  logic [CHAIN_LEN-1:0] chain;

  int n_checks;
  int n_fail;
  int done_cnt;

  typedef struct {
    logic [7:0] tx;       // load word
    logic [7:0] rx_pat;   // bits presented on scan_in, shift 0 first
    logic [7:0] exp_out;  // expected readback word
  } vec_t;

  vec_t vecs [6];

  scan_chain_driver #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .scan_en   (scan_en),
    .scan_out  (scan_out),
    .scan_in   (scan_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural scan chain as long as the whole chain: a bit comes back
  // CHAIN_LEN shifts after it went in.
  assign scan_in = loop_mode ? chain[CHAIN_LEN-1] : scan_in_drv;

  always @(posedge clk) begin
    if (chain_clr) chain <= '0;
    else if (scan_en) chain <= {chain[CHAIN_LEN-2:0], scan_out};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    chain_clr = 1'b1;
    clk_edge();
    clk_edge();
    reset     = 1'b0;
    chain_clr = 1'b0;
    done_cnt  = 0;
  endtask

  // Load one word and shift it out with no stall at the last bit.
  task automatic shift_word(input logic [7:0] tx, input logic [7:0] rx);
    in_valid = 1'b1;
    in_data  = tx;
    settle();
    chk("load_in_ready", in_ready, 1);
    clk_edge();
    in_valid = 1'b0;
    in_data  = ~tx;   // must not disturb the word being shifted
    for (int i = 0; i < 8; i++) begin
      scan_in_drv = rx[i];
      settle();
      chk("shift_scan_en", scan_en, 1);
      chk("shift_scan_out", scan_out, tx[i]);
      if (i == 0) chk("shift_in_ready", in_ready, 0);
      clk_edge();
    end
  endtask

  initial begin
    logic [7:0] tx2;
    logic [7:0] rx2;

    n_checks    = 0;
    n_fail      = 0;
    done_cnt    = 0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b1;
    scan_in_drv = 1'b0;
    loop_mode   = 1'b0;
    chain_clr   = 1'b1;
    reset       = 1'b1;

    // Reset state
    clk_edge();
    clk_edge();
    settle();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_scan_en", scan_en, 0);
    chk("rst_scan_out", scan_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    reset     = 1'b0;
    chain_clr = 1'b0;
    done_cnt  = 0;
    settle();
    chk("post_rst_in_ready", in_ready, 1);

    // Table-driven single words; 0xA5 must shift as 1,0,1,0,0,1,0,1.
    vecs[0] = '{tx: 8'hA5, rx_pat: 8'hFF, exp_out: 8'hFF};
    vecs[1] = '{tx: 8'h3C, rx_pat: 8'h00, exp_out: 8'h00};
    vecs[2] = '{tx: 8'h01, rx_pat: 8'h80, exp_out: 8'h80};
    vecs[3] = '{tx: 8'h80, rx_pat: 8'h01, exp_out: 8'h01};
    vecs[4] = '{tx: 8'hFF, rx_pat: 8'h5A, exp_out: 8'h5A};
    vecs[5] = '{tx: 8'h00, rx_pat: 8'hC3, exp_out: 8'hC3};
    for (int v = 0; v < 6; v++) begin
      shift_word(vecs[v].tx, vecs[v].rx_pat);
      settle();
      chk("vec_out_valid", out_valid, 1);
      chk("vec_out_data", out_data, vecs[v].exp_out);
      chk("vec_in_ready", in_ready, 1);
      chk("vec_scan_en_idle", scan_en, 0);
    end
    chk("vec_no_early_done", done_cnt, 0);
    clk_edge();
    settle();
    chk("vec_out_valid_clear", out_valid, 0);
    chk("idle_scan_out", scan_out, 0);

    // Loopback through the 64-bit chain: 16 words 0x00..0x0F
    do_reset();
    loop_mode = 1'b1;
    out_ready = 1'b1;
    for (int w = 0; w < 16; w++) begin
      shift_word(8'(w), 8'h00);
      settle();
      chk("loop_out_valid", out_valid, 1);
      chk("loop_out_data", out_data, (w < 8) ? 0 : (w - 8));
      if (w == 6) chk("loop_no_done_56", done_cnt, 0);
      if (w == 7) begin
        chk("loop_done_64", done_cnt, 1);
        chk("loop_done_pulse", done, 1);
      end
    end
    chk("loop_done_128", done_cnt, 2);
    clk_edge();
    settle();
    chk("loop_done_one_cycle", done, 0);
    loop_mode = 1'b0;

    // Backpressure: second word stalls at index 7
    do_reset();
    out_ready = 1'b0;
    shift_word(8'h12, 8'h3C);
    settle();
    chk("bp_w1_valid", out_valid, 1);
    chk("bp_w1_data", out_data, 8'h3C);
    tx2 = 8'h34;
    rx2 = 8'hA9;
    in_valid = 1'b1;
    in_data  = tx2;
    settle();
    chk("bp_w2_in_ready", in_ready, 1);
    clk_edge();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      scan_in_drv = rx2[i];
      settle();
      chk("bp_w2_scan_en", scan_en, 1);
      chk("bp_w2_scan_out", scan_out, tx2[i]);
      chk("bp_w1_stable", out_data, 8'h3C);
      clk_edge();
    end
    scan_in_drv = rx2[7];
    for (int s = 0; s < 3; s++) begin
      settle();
      chk("bp_stall_scan_en", scan_en, 0);
      chk("bp_stall_scan_out", scan_out, 0);
      chk("bp_stall_valid", out_valid, 1);
      chk("bp_stall_data", out_data, 8'h3C);
      clk_edge();
    end
    out_ready = 1'b1;
    settle();
    chk("bp_release_scan_en", scan_en, 1);
    chk("bp_release_scan_out", scan_out, tx2[7]);
    clk_edge();
    settle();
    chk("bp_w2_valid", out_valid, 1);
    chk("bp_w2_data", out_data, 8'hA9);
    chk("bp_in_ready", in_ready, 1);
    clk_edge();
    settle();
    chk("bp_no_dup", out_valid, 0);

    // Simultaneous consume of word N and completion of word N+1
    do_reset();
    out_ready = 1'b0;
    shift_word(8'h5A, 8'h66);
    settle();
    chk("sim_wN_valid", out_valid, 1);
    chk("sim_wN_data", out_data, 8'h66);
    tx2 = 8'hC3;
    rx2 = 8'h99;
    in_valid = 1'b1;
    in_data  = tx2;
    clk_edge();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      scan_in_drv = rx2[i];
      settle();
      chk("sim_scan_en", scan_en, 1);
      clk_edge();
    end
    out_ready   = 1'b1;
    scan_in_drv = rx2[7];
    settle();
    chk("sim_last_scan_en", scan_en, 1);
    clk_edge();
    out_ready = 1'b0;
    settle();
    chk("sim_valid_kept", out_valid, 1);
    chk("sim_new_data", out_data, 8'h99);
    clk_edge();
    settle();
    chk("sim_valid_hold", out_valid, 1);
    chk("sim_data_hold", out_data, 8'h99);
    out_ready = 1'b1;
    clk_edge();
    settle();
    chk("sim_consumed", out_valid, 0);

    // Reset at index 3 of a word
    do_reset();
    out_ready = 1'b0;
    shift_word(8'hF0, 8'hAA);
    in_valid = 1'b1;
    in_data  = 8'h0F;
    clk_edge();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rmw_scan_en", scan_en, 1);
      clk_edge();
    end
    reset = 1'b1;
    settle();
    chk("rmw_scan_en_off", scan_en, 0);
    chk("rmw_scan_out_off", scan_out, 0);
    chk("rmw_in_ready", in_ready, 0);
    clk_edge();
    settle();
    chk("rmw_scan_en_after", scan_en, 0);
    chk("rmw_out_valid", out_valid, 0);
    chk("rmw_out_data", out_data, 0);
    chk("rmw_done", done, 0);
    reset     = 1'b0;
    done_cnt  = 0;
    out_ready = 1'b1;
    settle();
    chk("rmw_in_ready_back", in_ready, 1);
    chk("rmw_idle_scan_en", scan_en, 0);
    for (int w = 0; w < 8; w++) begin
      shift_word(8'(w + 32), 8'(w * 3));
      settle();
      chk("rmw_word_data", out_data, 8'(w * 3));
      if (w == 6) chk("rmw_no_done_56", done_cnt, 0);
    end
    chk("rmw_done_64", done_cnt, 1);
    chk("rmw_done_pulse", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
